spi_master_mode0: RTL
=====================

SPI_MASTER_MODE0 -- requirements
Module: spi_master_mode0

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning SCLK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  transfer request, sampled only while ready=1.
REQ-005 SHALL have port cont  input  1  sampled with start; 1 keeps CS low after the byte (burst).
REQ-006 SHALL have port stop  input  1  ends a held burst (HOLD state only).
REQ-007 SHALL have port tx_byte  input  8  byte to send, MSB first, captured on accept.
REQ-008 SHALL have port ready  output  1  high in IDLE and HOLD only.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a byte completes.
REQ-010 SHALL have port rx_byte  output  8  received byte, valid from done until the next accept.
REQ-011 SHALL have port spi_sclk  output  1  serial clock, idle low (mode 0).
REQ-012 SHALL have port spi_cs_n  output  1  chip select, active low.
REQ-013 SHALL have port spi_mosi  output  1  serial data out.
REQ-014 SHALL have port spi_miso  input  1  serial data in.

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD and GAP, with a half-period counter and a 3-bit bit counter.
REQ-016 SHALL register spi_sclk, spi_cs_n and spi_mosi, with no combinational path from inputs to pins.
REQ-017 Accept condition: start=1 and ready=1; on accept SHALL capture tx_byte and cont, and enter SETUP.
REQ-018 SETUP SHALL drive cs_n=0 and mosi=tx[7] from cycle accept+1, and hold them for DIV cycles.
REQ-019 SHIFT_HI SHALL drive sclk=1 for DIV cycles and shift miso into the rx shift register (MSB first) on the clk edge that raises sclk.
REQ-020 SHIFT_LO SHALL drive sclk=0 for DIV cycles and present the next tx bit on mosi on the clk edge that lowers sclk, except after bit 0.
REQ-021 SHALL produce exactly 8 rising SCLK edges per byte, with a 50% duty cycle of DIV/DIV clk cycles.
REQ-022 done SHALL pulse in cycle accept+1+16*DIV, and rx_byte SHALL update in that same cycle.
REQ-023 After the byte, with cont=1 the block SHALL enter HOLD with cs_n=0 and sclk=0; with cont=0 it SHALL enter GAP.
REQ-024 In HOLD, start=1 SHALL be accepted and SHALL re-enter SETUP with cs_n staying low, giving a continuous burst.
REQ-025 In HOLD, stop=1 with start=0 SHALL enter GAP; if start and stop are both 1, start SHALL win and stop SHALL be ignored.
REQ-026 GAP SHALL drive cs_n=1 for DIV cycles and then go to IDLE; ready=0 throughout GAP.
REQ-027 In IDLE, the block SHALL drive cs_n=1, sclk=0 and mosi=0.
REQ-028 start asserted while ready=0 SHALL be ignored, with no queuing.
REQ-029 stop asserted outside HOLD SHALL be ignored.
REQ-030 rx_byte SHALL hold its value between done and the next accept; the shift register is internal.

Reset
REQ-031 rst=1 SHALL force IDLE within one clk edge, from any state including mid-byte and HOLD.
REQ-032 Reset values SHALL be: cs_n=1, sclk=0, mosi=0, done=0, rx_byte=8'h00, ready=1, counters 0.
REQ-033 A mid-byte reset SHALL NOT produce done, and rx_byte SHALL read 8'h00 after reset.

Verification
REQ-034 Single byte, DIV=4, tx=8'hA5, slave returns 8'h3C: mosi shows 1,0,1,0,0,1,0,1 at the sclk rises; 8 rises occur; done at cycle 65 after accept; rx_byte=8'h3C; cs_n high at cycle 66 for 4 cycles; ready at cycle 70.
REQ-035 Burst: tx 8'h01 with cont=1, then 8'h80 with cont=0: cs_n stays low between the bytes; 16 rises total; two done pulses; cs_n rises once.
REQ-036 HOLD then stop=1: cs_n rises the next cycle; no extra sclk edges; ready returns after DIV cycles.
REQ-037 start pulsed during SHIFT_HI: ignored; the current byte completes unchanged; exactly one done.
REQ-038 rst asserted at the 4th sclk rise: next cycle cs_n=1, sclk=0, ready=1; no done; rx_byte=8'h00.
REQ-039 DIV=1, tx=8'hFF with miso held at 1: sclk toggles every cycle; done at cycle 17 after accept; rx_byte=8'hFF.

Source files
------------

// File: rtl/spi_master_mode0.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), one byte per request, MSB first, optional CS-held bursts.
// Latency: done pulses 1+16*DIV cycles after the accept cycle; CS released one cycle after done.
// Backpressure: ready is high only in IDLE/HOLD; start while not ready is dropped, never queued.
module spi_master_mode0 #(
  parameter int DIV = 4  // SCLK half-period in clk cycles, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic [7:0] tx_byte,
  output logic       ready,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_HOLD     = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  localparam logic [7:0] LP_HALF_MAX = 8'(DIV - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_half_cnt;
  logic [7:0] w_half_nxt;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_nxt;
  // Only bits 6..0 are kept: bit 7 goes straight to mosi on accept.
  logic [6:0] r_tx_sh;
  logic [6:0] w_tx_nxt;
  logic [7:0] r_rx_sh;
  logic [7:0] w_rx_sh_nxt;
  logic [7:0] r_rx_byte;
  logic [7:0] w_rx_byte_nxt;
  logic       r_cont;
  logic       w_cont_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic       r_sclk;
  logic       w_sclk_nxt;
  logic       r_cs_n;
  logic       w_cs_n_nxt;
  logic       r_mosi;
  logic       w_mosi_nxt;
  logic       w_last_half;

  assign w_last_half = (r_half_cnt == LP_HALF_MAX);

  // Next-state and next-pin computation; pins are registered from these values.
  always_comb begin
    w_state_nxt   = r_state;
    w_half_nxt    = r_half_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_tx_nxt      = r_tx_sh;
    w_rx_sh_nxt   = r_rx_sh;
    w_rx_byte_nxt = r_rx_byte;
    w_cont_nxt    = r_cont;
    w_done_nxt    = 1'b0;
    w_sclk_nxt    = r_sclk;
    w_cs_n_nxt    = r_cs_n;
    w_mosi_nxt    = r_mosi;

    unique case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (start) begin
          // Accept: from HOLD cs_n is already low, so a burst continues seamlessly.
          w_state_nxt = ST_SETUP;
          w_half_nxt  = 8'd0;
          w_bit_nxt   = 3'd7;
          w_tx_nxt    = tx_byte[6:0];
          w_cont_nxt  = cont;
          w_cs_n_nxt  = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_mosi_nxt  = tx_byte[7];
        end else if ((r_state == ST_HOLD) && stop) begin
          w_state_nxt = ST_GAP;
          w_half_nxt  = 8'd0;
          w_cs_n_nxt  = 1'b1;
          w_sclk_nxt  = 1'b0;
          w_mosi_nxt  = 1'b0;
        end
      end

      ST_SETUP: begin
        if (w_last_half) begin
          w_state_nxt = ST_SHIFT_HI;
          w_half_nxt  = 8'd0;
          w_sclk_nxt  = 1'b1;
          w_rx_sh_nxt = {r_rx_sh[6:0], spi_miso};
        end else begin
          w_half_nxt  = r_half_cnt + 8'd1;
        end
      end

      ST_SHIFT_HI: begin
        if (w_last_half) begin
          w_state_nxt = ST_SHIFT_LO;
          w_half_nxt  = 8'd0;
          w_sclk_nxt  = 1'b0;
          if (r_bit_cnt == 3'd0) begin
            // Last bit sampled on the previous rise: publish the byte now.
            w_done_nxt    = 1'b1;
            w_rx_byte_nxt = r_rx_sh;
          end else begin
            w_mosi_nxt = r_tx_sh[6];
            w_tx_nxt   = {r_tx_sh[5:0], 1'b0};
            w_bit_nxt  = r_bit_cnt - 3'd1;
          end
        end else begin
          w_half_nxt = r_half_cnt + 8'd1;
        end
      end

      ST_SHIFT_LO: begin
        if (r_done) begin
          // Final low phase is a single cycle (the done cycle); then leave the byte.
          w_half_nxt = 8'd0;
          if (r_cont) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_GAP;
            w_cs_n_nxt  = 1'b1;
            w_mosi_nxt  = 1'b0;
          end
        end else if (w_last_half) begin
          w_state_nxt = ST_SHIFT_HI;
          w_half_nxt  = 8'd0;
          w_sclk_nxt  = 1'b1;
          w_rx_sh_nxt = {r_rx_sh[6:0], spi_miso};
        end else begin
          w_half_nxt = r_half_cnt + 8'd1;
        end
      end

      ST_GAP: begin
        if (w_last_half) begin
          w_state_nxt = ST_IDLE;
          w_half_nxt  = 8'd0;
        end else begin
          w_half_nxt = r_half_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_half_nxt  = 8'd0;
        w_cs_n_nxt  = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_mosi_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters, shift registers and registered pins, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_half_cnt <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_tx_sh    <= 7'd0;
      r_rx_sh    <= 8'd0;
      r_rx_byte  <= 8'd0;
      r_cont     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_half_cnt <= w_half_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_tx_sh    <= w_tx_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_byte  <= w_rx_byte_nxt;
      r_cont     <= w_cont_nxt;
      r_done     <= w_done_nxt;
      r_sclk     <= w_sclk_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_mosi     <= w_mosi_nxt;
    end
  end

  assign ready    = (r_state == ST_IDLE) || (r_state == ST_HOLD);
  assign done     = r_done;
  assign rx_byte  = r_rx_byte;
  assign spi_sclk = r_sclk;
  assign spi_cs_n = r_cs_n;
  assign spi_mosi = r_mosi;

endmodule
